// File: rtl/contour_point_streamer_if.sv
// Stream bundle for the contour point streamer: bitmap frame in, sparse points out.
// The master modport is the streamer itself; slave is the producer/consumer side.
interface contour_point_streamer_if;
    localparam int N = 468;

    logic [N-1:0] frame_in;
    logic         frame_valid;
    logic         frame_ready;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   out_row;
    logic [4:0]   out_col;
    logic         out_last;
    logic         out_null;
    logic [8:0]   out_count;

    modport master (
        input  frame_in, frame_valid, out_ready,
        output frame_ready, out_valid, out_row, out_col, out_last, out_null, out_count
    );

    modport slave (
        output frame_in, frame_valid, out_ready,
        input  frame_ready, out_valid, out_row, out_col, out_last, out_null, out_count
    );
endinterface

// File: rtl/contour_point_streamer.sv
// Snapshots a 26x18 contour bitmap and streams the (row, col) of each set bit
// in raster order, one beat per cycle, with a last marker and a null beat for empty frames.
module contour_point_streamer (
    input  logic clk,
    input  logic rst,
    contour_point_streamer_if.master bus
);
    localparam int COLS = 26;
    localparam int ROWS = 18;
    localparam int N    = ROWS * COLS;

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t       r_state,   w_state_nxt;
    logic [N-1:0] r_shadow,  w_shadow_nxt;
    logic [4:0]   r_row_ptr, w_row_ptr_nxt;
    logic [8:0]   r_cnt,     w_cnt_nxt;
    logic         r_valid,   w_valid_nxt;
    logic         r_last,    w_last_nxt;
    logic         r_null,    w_null_nxt;
    logic [4:0]   r_row,     w_row_nxt;
    logic [4:0]   r_col,     w_col_nxt;
    logic [8:0]   r_count,   w_count_nxt;

    logic [8:0]      w_base;
    logic [COLS-1:0] w_row_bits;
    logic [COLS-1:0] w_row_rest;
    logic [4:0]      w_low_col;
    logic            w_row_has;
    logic [N-1:0]    w_shadow_clr;
    logic            w_shadow_clr_zero;
    logic            w_xfer;
    logic            w_slot_free;

    // Current row slice and its lowest set bit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_base       = 9'(r_row_ptr) * 9'(COLS);
        w_row_bits   = r_shadow[w_base +: COLS];
        w_row_has    = |w_row_bits;
        w_low_col    = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (w_row_bits[c]) w_low_col = 5'(c);
        end
        w_row_rest   = w_row_bits & ~({{(COLS-1){1'b0}}, 1'b1} << w_low_col);
        w_shadow_clr = r_shadow;
        w_shadow_clr[w_base + 9'(w_low_col)] = 1'b0;
        w_shadow_clr_zero = (w_shadow_clr == '0);
    end

    assign w_xfer      = r_valid && bus.out_ready;
    assign w_slot_free = !r_valid || bus.out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_shadow_nxt  = r_shadow;
        w_row_ptr_nxt = r_row_ptr;
        w_cnt_nxt     = r_cnt;
        w_valid_nxt   = r_valid;
        w_last_nxt    = r_last;
        w_null_nxt    = r_null;
        w_row_nxt     = r_row;
        w_col_nxt     = r_col;
        w_count_nxt   = r_count;

        case (r_state)
            S_IDLE: begin
                if (bus.frame_valid) begin
                    w_shadow_nxt  = bus.frame_in;
                    w_row_ptr_nxt = '0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_xfer) begin
                    w_valid_nxt = 1'b0;
                    if (r_last) w_state_nxt = S_IDLE;
                end
                // The last beat's transfer ends the frame; nothing more is loaded behind it.
                if (w_slot_free && !(w_xfer && r_last)) begin
                    if (r_shadow == '0) begin
                        w_valid_nxt = 1'b1;
                        w_null_nxt  = 1'b1;
                        w_last_nxt  = 1'b1;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                        w_count_nxt = '0;
                    end else if (!w_row_has) begin
                        w_row_ptr_nxt = r_row_ptr + 5'd1;
                    end else begin
                        w_valid_nxt  = 1'b1;
                        w_null_nxt   = 1'b0;
                        w_last_nxt   = w_shadow_clr_zero;
                        w_row_nxt    = r_row_ptr;
                        w_col_nxt    = w_low_col;
                        w_count_nxt  = r_cnt + 9'd1;
                        w_cnt_nxt    = r_cnt + 9'd1;
                        w_shadow_nxt = w_shadow_clr;
                        // Holding row_ptr on the final point keeps it inside 0..17.
                        if (w_row_rest == '0 && !w_shadow_clr_zero)
                            w_row_ptr_nxt = r_row_ptr + 5'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shadow  <= '0;
            r_row_ptr <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_null    <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
            r_count   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state   <= w_state_nxt;
            r_shadow  <= w_shadow_nxt;
            r_row_ptr <= w_row_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_last    <= w_last_nxt;
            r_null    <= w_null_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign bus.frame_ready = (r_state == S_IDLE);
    assign bus.out_valid   = r_valid;
    assign bus.out_last    = r_last;
    assign bus.out_null    = r_null;
    assign bus.out_row     = r_row;
    assign bus.out_col     = r_col;
    assign bus.out_count   = r_count;
endmodule

// File: doc/contour_point_streamer.md
# contour_point_streamer

- Downstream consumer of the 26x18 contour mesh's 468-bit contour bitmap.
- On each accepted frame it snapshots the bitmap and emits the (row, col) coordinate of every set bit, one beat at a time, over a valid/ready stream in raster order.
- It marks the final beat of each frame and emits a single null beat for frames with no points.
- It sits between the mesh and the tracking/host logic that consumes sparse contour points instead of the full bitmap.

## Interface

- COLS, 26, columns per row; bit k of the frame is row k/COLS, col k%COLS.
- ROWS, 18, rows per frame; frame width N = ROWS*COLS = 468.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- frame_in  in  468  contour bitmap; 1 = contour point. Sampled only on the accept edge.
- frame_valid  in  1  frame_in is presented.
- frame_ready  out  1  high only in IDLE; a frame is accepted on an edge where frame_valid and frame_ready are both high.
- out_valid  out  1  output beat is valid.
- out_ready  in  1  consumer accepts the beat; a transfer occurs on an edge where out_valid and out_ready are both high.
- out_row  out  5  point row, 0..17.
- out_col  out  5  point column, 0..25.
- out_last  out  1  final beat of the frame.
- out_null  out  1  frame contained no points; row, col and count are 0.
- out_count  out  9  1-based ordinal of this point within the frame; 0 on a null beat.

## Operation

- State machine has two states, IDLE and SCAN.
- **IDLE**
  - frame_ready = 1.
  - On accept: shadow <= frame_in, row_ptr <= 0, cnt <= 0, go to SCAN.
- **SCAN**
  - frame_ready = 0 and frame_valid is ignored.
  - The scanner advances only when the output slot is free, i.e. !out_valid, or out_valid && out_ready on the same edge.
  - Per advancing cycle:
    - **Empty frame:** if shadow == 0 on the first SCAN cycle, load a null beat (out_null=1, out_last=1, row=col=count=0).
    - **Empty row:** if the shadow row slice [row_ptr] is 0, row_ptr <= row_ptr+1 and nothing is loaded.
    - **Non-empty row:** take c = lowest set bit in the row slice.
      - Load out_row=row_ptr, out_col=c, out_count=cnt+1.
      - Clear that bit in shadow; cnt <= cnt+1.
      - If it was the row's only remaining bit, row_ptr <= row_ptr+1 in the same cycle.
      - out_last = 1 when shadow, with that bit cleared, is all zero.
- When a beat with out_last=1 transfers, clear out_valid and return to IDLE.
- Output beat fields stay stable while out_valid && !out_ready.
- row_ptr never exceeds 17 in SCAN, because out_last fires before row_ptr would pass the last non-empty row.
- cnt is 9 bits; the maximum is 468, so it never wraps.

## Timing

- **Reset values:** state IDLE, frame_ready=1, out_valid=0, out_row=0, out_col=0, out_last=0, out_null=0, out_count=0, shadow=0.
- **Reset mid-frame:** the frame is aborted and out_valid drops immediately (asynchronously). No partial frame resumes.
- **First beat:** with the frame accepted at edge k, the first beat is valid after edge k+1+E, where E = number of empty rows before the first non-empty row.
  - An empty frame gives its null beat after edge k+1.
- **Throughput with out_ready held high:**
  - one point per cycle within and across rows;
  - plus one bubble cycle per empty row lying between points.
- **Earliest next accept:** frame_ready rises the cycle after the last beat transfers, so the next frame can be accepted no earlier than edge j+1 when the last beat transfers at edge j.
- Frame latency is bounded by 18 + number of points cycles, excluding backpressure.

## Test plan

- **Reset:** assert rst mid-stream -> out_valid=0 and frame_ready=1 immediately. Deassert -> idle, no beats.
- **Single point:** frame with only bit 27 set, out_ready=1 -> one beat after edge k+2: row=1, col=1, count=1, last=1, null=0. frame_ready=1 on the following cycle.
- **Empty frame:** all-zero frame -> one beat after edge k+1 with null=1, last=1, count=0. Return to IDLE.
- **Row 0 plus one distant point:** bits 0..25 and 467 set, out_ready=1 -> 27 beats total.
  - Row 0, cols 0..25, on 26 consecutive cycles, counts 1..26.
  - Then 16 empty cycles.
  - Then row=17, col=25, count=27, last=1.
- **Backpressure and busy frames:** points {3, 100, 300} with out_ready toggling 1/0/0/1… -> beats (0,3), (3,22), (11,14) in order, each held stable while stalled, last on the third. A frame_valid pulse during SCAN is not accepted.
- **Full frame:** all 468 bits set -> 468 beats on consecutive cycles, raster order, count reaches 468, out_last only on (17,25).
